// File: rtl/dc_block_pkg.sv
// Shared types, default widths and the saturation helper for the DC-blocker scheduler.
package dc_block_pkg;

  localparam int unsigned DW_DEF       = 8;
  localparam int unsigned AW_DEF       = 32;
  localparam int unsigned DIV_LOG2_DEF = 16;
  localparam int unsigned KW           = 5;

  typedef enum logic [2:0] {
    IDLE,
    CAP,
    UPD_I,
    UPD_Q,
    DONE
  } state_e;

  // Clamp a signed value to the range of a w-bit two's-complement number.
  function automatic logic signed [31:0] sat_s(input logic signed [31:0] y,
                                               input int unsigned        w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 32'd1));
    if (y > hi) return hi;
    if (y < lo) return lo;
    return y;
  endfunction

endpackage

// File: rtl/dcb_alu.sv
// Shared subtract/saturate/accumulate step of the leaky DC blocker.
module dcb_alu
  import dc_block_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic signed [DW-1:0] x_i,
  input  logic signed [AW-1:0] acc_i,
  input  logic [KW-1:0]        k_i,
  output logic signed [DW-1:0] y_o,
  output logic signed [AW-1:0] acc_next_o
);

  localparam int unsigned KMAX = AW - DW;

  logic signed [DW-1:0] lvl;
  logic signed [DW:0]   y;
  logic signed [AW-1:0] y_ext;
  logic [31:0]          shamt;

  // Remove the current DC level, saturate the result, and leak it into the accumulator.
  always_comb begin
    lvl        = acc_i[AW-1 -: DW];
    y          = (DW+1)'(x_i) - (DW+1)'(lvl);
    y_o        = DW'(sat_s(32'(y), DW));
    y_ext      = AW'(y);
    shamt      = 32'(KMAX) - 32'(k_i);
    acc_next_o = acc_i + (y_ext <<< shamt);
  end

endmodule

// File: rtl/dc_block_sched.sv
// Time-multiplexed I/Q DC-blocking filter: tick divider, sequencer, per-channel accumulators.
module dc_block_sched
  import dc_block_pkg::*;
#(
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DIV_LOG2 = DIV_LOG2_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] i_in,
  input  logic signed [DW-1:0] q_in,
  input  logic [KW-1:0]        cfg_shift,
  input  logic                 freeze,
  output logic signed [DW-1:0] i_out,
  output logic signed [DW-1:0] q_out,
  output logic                 out_valid,
  output logic                 overrun
);

  localparam int unsigned KMAX = AW - DW;

  logic [DIV_LOG2-1:0]  cnt_q;
  logic                 tick;
  state_e               state_q;
  state_e               state_d;
  logic signed [DW-1:0] xi_q;
  logic signed [DW-1:0] xq_q;
  logic [KW-1:0]        k_q;
  logic [KW-1:0]        k_clamp;
  logic                 frz_q;
  logic signed [AW-1:0] dci_q;
  logic signed [AW-1:0] dcq_q;
  logic signed [DW-1:0] i_out_q;
  logic signed [DW-1:0] q_out_q;
  logic                 out_valid_q;
  logic                 overrun_q;
  logic signed [DW-1:0] alu_x;
  logic signed [AW-1:0] alu_acc;
  logic signed [DW-1:0] alu_y;
  logic signed [AW-1:0] alu_acc_next;

  assign tick    = &cnt_q;
  assign k_clamp = (32'(cfg_shift) > KMAX) ? KW'(KMAX) : cfg_shift;

  assign i_out     = i_out_q;
  assign q_out     = q_out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

  // Free-running divider; tick fires when the counter is all ones.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_q + DIV_LOG2'(1);
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and ALU operand selection (Q pair only during UPD_Q).
  always_comb begin
    state_d = state_q;
    alu_x   = xi_q;
    alu_acc = dci_q;
    case (state_q)
      IDLE:    if (tick) state_d = CAP;
      CAP:     state_d = UPD_I;
      UPD_I:   state_d = UPD_Q;
      UPD_Q:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q == UPD_Q) begin
      alu_x   = xq_q;
      alu_acc = dcq_q;
    end
  end

  dcb_alu #(
    .DW(DW),
    .AW(AW)
  ) u_alu (
    .x_i       (alu_x),
    .acc_i     (alu_acc),
    .k_i       (k_q),
    .y_o       (alu_y),
    .acc_next_o(alu_acc_next)
  );

  // Capture samples and per-tick configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      xi_q  <= '0;
      xq_q  <= '0;
      k_q   <= '0;
      frz_q <= 1'b0;
    end else if (state_q == CAP) begin
      xi_q  <= i_in;
      xq_q  <= q_in;
      k_q   <= k_clamp;
      frz_q <= freeze;
    end
  end

  // Per-channel output and accumulator update; accumulators hold while frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      dci_q   <= '0;
      dcq_q   <= '0;
      i_out_q <= '0;
      q_out_q <= '0;
    end else begin
      if (state_q == UPD_I) begin
        i_out_q <= alu_y;
        if (!frz_q) dci_q <= alu_acc_next;
      end
      if (state_q == UPD_Q) begin
        q_out_q <= alu_y;
        if (!frz_q) dcq_q <= alu_acc_next;
      end
    end
  end

  // Completion pulse and sticky overrun flag for ticks arriving mid-sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= (state_d == DONE);
      if (tick && (state_q != IDLE)) overrun_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dc_block_sched.sv
// Self-checking bench for dc_block_sched against an arithmetic DC-blocker model.
module tb_dc_block_sched;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] i_in;
  logic signed [7:0] q_in;
  logic [4:0]        cfg_shift;
  logic              freeze;
  logic signed [7:0] i_out;
  logic signed [7:0] q_out;
  logic              out_valid;
  logic              overrun;

  int     n_chk  = 0;
  int     n_fail = 0;
  longint m_dci  = 0;
  longint m_dcq  = 0;

  always #5 clk = ~clk;

  dc_block_sched #(
    .DW(8),
    .AW(32),
    .DIV_LOG2(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_in     (i_in),
    .q_in     (q_in),
    .cfg_shift(cfg_shift),
    .freeze   (freeze),
    .i_out    (i_out),
    .q_out    (q_out),
    .out_valid(out_valid),
    .overrun  (overrun)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sat8(input longint v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic longint wrap32(input longint v);
    int t;
    t = int'(v);
    return longint'(t);
  endfunction

  // Accumulator holds the DC level scaled by 2^24; one leaky update per tick.
  task automatic model_step(input longint x, input int k, input bit frz,
                            inout longint dc, output longint o);
    longint lvl;
    longint y;
    int     kk;
    kk  = (k > 24) ? 24 : k;
    lvl = dc >>> 24;
    y   = x - lvl;
    o   = sat8(y);
    if (!frz) dc = wrap32(dc + y * (longint'(1) << (24 - kk)));
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid !== 1'b1 && n < 64);
    if (out_valid !== 1'b1) check("timeout out_valid", longint'(out_valid), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    m_dci = 0;
    m_dcq = 0;
    rst   = 1'b0;
  endtask

  task automatic run_tick(input int xi, input int xq, input int k, input bit frz,
                          input int exp_gap, input string tag);
    int     n;
    longint ei;
    longint eq;
    i_in      = 8'(xi);
    q_in      = 8'(xq);
    cfg_shift = 5'(k);
    freeze    = frz;
    wait_valid(n);
    if (exp_gap > 0) check({tag, " gap"}, n, exp_gap);
    model_step(xi, k, frz, m_dci, ei);
    model_step(xq, k, frz, m_dcq, eq);
    check({tag, " i_out"}, i_out, ei);
    check({tag, " q_out"}, q_out, eq);
    check({tag, " dc_i"}, dut.dci_q, m_dci);
    check({tag, " dc_q"}, dut.dcq_q, m_dcq);
    @(negedge clk);
    check({tag, " pulse"}, longint'(out_valid), 0);
  endtask

  initial begin
    longint prev_o;
    longint prev_l;
    longint ei;
    longint eq;
    rst = 1'b1; i_in = '0; q_in = '0; cfg_shift = '0; freeze = 1'b0;
    repeat (3) @(negedge clk);
    check("rst i_out", i_out, 0);
    check("rst q_out", q_out, 0);
    check("rst out_valid", longint'(out_valid), 0);
    check("rst overrun", longint'(overrun), 0);
    rst = 1'b0;

    // k=0 constant input: first output passes, later outputs cancel
    run_tick(64, -32, 0, 0, 11, "t1");
    repeat (3) run_tick(64, -32, 0, 0, 7, "t1");

    // level -100 then a jump to 127 saturates
    repeat (2) run_tick(-100, 5, 0, 0, 7, "t2");
    run_tick(127, 5, 0, 0, 7, "t2 sat");
    run_tick(127, 5, 0, 0, 7, "t2");

    // k=4 slow convergence from reset
    do_reset();
    run_tick(16, 0, 4, 0, 11, "t3");
    prev_o = i_out;
    prev_l = $signed(dut.dci_q[31:24]);
    for (int i = 0; i < 11; i++) begin
      run_tick(16, 0, 4, 0, 7, "t3");
      check("t3 out non-increasing", longint'(i_out <= prev_o), 1);
      check("t3 level non-decreasing", longint'($signed(dut.dci_q[31:24]) >= prev_l), 1);
      prev_o = i_out;
      prev_l = $signed(dut.dci_q[31:24]);
    end

    // freeze holds the accumulators
    do_reset();
    run_tick(50, -77, 0, 1, 11, "t4 frz");
    repeat (3) run_tick(50, -77, 0, 1, 7, "t4 frz");
    run_tick(50, -77, 0, 0, 7, "t4 thaw");
    run_tick(50, -77, 0, 0, 7, "t4 thaw");

    // reset landing in UPD_I discards the update
    run_tick(33, -44, 0, 0, 7, "t5 pre");
    i_in = 8'sd20; q_in = -8'sd20;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5 i_out", i_out, 0);
    check("t5 q_out", q_out, 0);
    check("t5 dc_i", dut.dci_q, 0);
    check("t5 dc_q", dut.dcq_q, 0);
    check("t5 out_valid", longint'(out_valid), 0);
    m_dci = 0;
    m_dcq = 0;
    rst   = 1'b0;
    run_tick(10, -10, 0, 0, 11, "t5 post");

    // forced tick during UPD_Q sets sticky overrun
    i_in = 8'sd70; q_in = -8'sd70; cfg_shift = 5'd2; freeze = 1'b0;
    repeat (6) @(negedge clk);
    check("t6 overrun before", longint'(overrun), 0);
    force dut.tick = 1'b1;
    @(negedge clk);
    release dut.tick;
    model_step(70, 2, 0, m_dci, ei);
    model_step(-70, 2, 0, m_dcq, eq);
    check("t6 out_valid", longint'(out_valid), 1);
    check("t6 overrun", longint'(overrun), 1);
    check("t6 i_out", i_out, ei);
    check("t6 q_out", q_out, eq);
    @(negedge clk);
    check("t6 pulse", longint'(out_valid), 0);
    run_tick(70, -70, 2, 0, 7, "t6 next");
    check("t6 overrun sticky", longint'(overrun), 1);

    // random samples, shifts (including clamped ones) and freeze
    for (int i = 0; i < 40; i++) begin
      run_tick(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
               int'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0), 7, "rnd");
    end
    check("end overrun sticky", longint'(overrun), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
